// File: rtl/dm_pkg.sv
// Shared definitions for the dm_param byte-lane data memory: access sizes, FSM
// state encoding, lane count and the alignment / lane-enable helpers.
package dm_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

  // Lane enables for a store; little-endian, lane 0 holds bits [7:0].
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dm_param_if.sv
// Request/response bundle of the dm_param memory; the master issues accesses
// and clear pulses, the slave (the memory) answers.
interface dm_param_if #(parameter int ADDR_W = 10);

  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       din;
  logic              clr;
  logic              ready;
  logic              rvalid;
  logic [31:0]       dout;
  logic              misalign;
  logic              busy;

  modport master (
    output req, we, size, sext, addr, din, clr,
    input  ready, rvalid, dout, misalign, busy
  );

  modport slave (
    input  req, we, size, sext, addr, din, clr,
    output ready, rvalid, dout, misalign, busy
  );

endinterface

// File: rtl/dm_load_align.sv
// Load path: picks the addressed byte/half out of a memory word and
// right-aligns it with sign or zero extension.
module dm_load_align
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = {{24{sext & b[7]}}, b};
      SZ_HALF: data = {{16{sext & h[15]}}, h};
      SZ_WORD: data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_param.sv
// Byte-addressable data memory with byte/half/word access, 1-cycle read
// latency, misalignment reporting and a hardware clear sequencer.
// Build option: define DM_PARAM_AUTOCLR_EN to start a full clear out of reset.
module dm_param
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic         clk,
  input logic         rst_n,
  dm_param_if.slave   bus
);

  localparam int WA    = ADDR_W - 2;
  localparam int WORDS = 2 ** WA;

`ifdef DM_PARAM_AUTOCLR_EN
  localparam state_t RST_STATE = ST_CLEAR;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t          state;
  logic [WA-1:0]   counter;
  logic [31:0]     mem [WORDS];

  logic            accept;
  logic            mis;
  logic            wr_en;
  logic [WA-1:0]   widx;
  logic [LANES-1:0] wmask;
  logic [31:0]     wdata;

  logic [31:0]     rd_word;
  logic [1:0]      rd_off;
  logic [1:0]      rd_size;
  logic            rd_sext;
  logic            rvalid_q;
  logic            mis_q;
  logic [31:0]     ld_data;

  assign bus.ready = (state == ST_IDLE) && !bus.clr;
  assign accept    = bus.req && bus.ready;
  assign mis       = is_misaligned(bus.size, bus.addr[1:0]);
  assign wr_en     = accept && bus.we && !mis;
  assign widx      = bus.addr[ADDR_W-1:2];
  assign wmask     = lane_mask(bus.size, bus.addr[1:0]);

  // Replicate narrow store data so each lane sees its slice at the same offset.
  always_comb begin
    case (bus.size)
      SZ_BYTE: wdata = {4{bus.din[7:0]}};
      SZ_HALF: wdata = {2{bus.din[15:0]}};
      default: wdata = bus.din;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_STATE;
      counter <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.clr) begin
            state   <= ST_CLEAR;
            counter <= '0;
          end
        end
        ST_CLEAR: begin
          counter <= counter + 1'b1;
          if (counter == '1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; clearing it is the job of the CLEAR sequence.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[counter] <= '0;
    end else if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (wmask[l]) mem[widx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
    if (accept && !bus.we) rd_word <= mem[widx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      rd_off   <= '0;
      rd_size  <= '0;
      rd_sext  <= 1'b0;
    end else begin
      rvalid_q <= accept && !bus.we;
      mis_q    <= accept && mis;
      if (accept) begin
        rd_off  <= bus.addr[1:0];
        rd_size <= bus.size;
        rd_sext <= bus.sext;
      end
    end
  end

  dm_load_align u_align (
    .word (rd_word),
    .off  (rd_off),
    .size (rd_size),
    .sext (rd_sext),
    .data (ld_data)
  );

  // A misaligned read still answers, but with zero data.
  assign bus.dout     = (rvalid_q && !mis_q) ? ld_data : '0;
  assign bus.rvalid   = rvalid_q;
  assign bus.misalign = mis_q;
  assign bus.busy     = (state == ST_CLEAR);

endmodule

// File: tb/tb_dm_param.sv
// Bench for dm_param (ADDR_W=10): table of accesses checked through a response
// scoreboard, plus clear, reset-during-read and reset-during-clear sequences.
module tb_dm_param;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_param_if #(.ADDR_W(10)) bus ();

  dm_param #(.ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [9:0]  addr;
    logic [31:0] din;
    logic        rv;
    logic        mis;
    logic [31:0] dout;
  } vec_t;

  typedef struct {
    string       name;
    logic        rv;
    logic        mis;
    logic [31:0] dout;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sext,
                              input logic [9:0] addr, input logic [31:0] din,
                              input logic rv, input logic mis, input logic [31:0] dout);
    vec_t v;
    v.we = we; v.size = size; v.sext = sext; v.addr = addr; v.din = din;
    v.rv = rv; v.mis = mis; v.dout = dout;
    return v;
  endfunction

  task automatic access(input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    bus.req = 1'b1; bus.we = v.we; bus.size = v.size; bus.sext = v.sext;
    bus.addr = v.addr; bus.din = v.din;
    e.name = nm; e.rv = v.rv; e.mis = v.mis; e.dout = v.dout;
    sb.push_back(e);
    #1 check({nm, "_ready"}, bus.ready, 1);
    @(posedge clk);
    #1 bus.req = 1'b0;
    e = sb.pop_front();
    check({e.name, "_rvalid"}, bus.rvalid, e.rv);
    check({e.name, "_misalign"}, bus.misalign, e.mis);
    check({e.name, "_dout"}, bus.dout, e.dout);
  endtask

  // Counts samples with busy high, starting from the current instant; optionally
  // fires a one-cycle clr pulse partway through, which must be ignored.
  task automatic count_busy(input string nm, input int pulse_at);
    int n = 0;
    logic ready_hi = 1'b0;
    logic rv_hi = 1'b0;
    while (bus.busy && n < 400) begin
      if (bus.ready) ready_hi = 1'b1;
      if (bus.rvalid || bus.misalign) rv_hi = 1'b1;
      bus.clr = (n == pulse_at);
      n++;
      @(posedge clk);
      #1;
    end
    bus.clr = 1'b0;
    check({nm, "_cycles"}, n, 256);
    check({nm, "_ready_low"}, ready_hi, 0);
    check({nm, "_no_resp"}, rv_hi, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.size = SZ_BYTE; bus.sext = 1'b0;
    bus.addr = '0; bus.din = '0; bus.clr = 1'b0;

    vecs.push_back(mk(1, SZ_WORD, 0, 10'h004, 32'h0000_0000, 0, 0, 32'h0));
    vecs.push_back(mk(1, SZ_BYTE, 0, 10'h005, 32'h0000_0080, 0, 0, 32'h0));
    vecs.push_back(mk(0, SZ_BYTE, 1, 10'h005, 32'h0,         1, 0, 32'hFFFF_FF80));
    vecs.push_back(mk(0, SZ_BYTE, 0, 10'h005, 32'h0,         1, 0, 32'h0000_0080));
    vecs.push_back(mk(1, SZ_WORD, 0, 10'h010, 32'h1122_3344, 0, 0, 32'h0));
    vecs.push_back(mk(1, SZ_HALF, 0, 10'h012, 32'h0000_BEEF, 0, 0, 32'h0));
    vecs.push_back(mk(0, SZ_WORD, 0, 10'h010, 32'h0,         1, 0, 32'hBEEF_3344));
    vecs.push_back(mk(0, SZ_HALF, 1, 10'h012, 32'h0,         1, 0, 32'hFFFF_BEEF));
    vecs.push_back(mk(0, SZ_HALF, 1, 10'h010, 32'h0,         1, 0, 32'h0000_3344));
    vecs.push_back(mk(0, SZ_BYTE, 1, 10'h011, 32'h0,         1, 0, 32'h0000_0033));
    vecs.push_back(mk(1, SZ_WORD, 0, 10'h006, 32'hDEAD_BEEF, 0, 1, 32'h0));
    vecs.push_back(mk(0, SZ_WORD, 0, 10'h004, 32'h0,         1, 0, 32'h0000_8000));
    vecs.push_back(mk(0, SZ_HALF, 0, 10'h001, 32'h0,         1, 1, 32'h0));
    vecs.push_back(mk(0, SZ_BAD,  0, 10'h000, 32'h0,         1, 1, 32'h0));
    vecs.push_back(mk(1, SZ_HALF, 0, 10'h003, 32'h0000_1234, 0, 1, 32'h0));
    vecs.push_back(mk(1, SZ_BAD,  0, 10'h008, 32'h0000_0055, 0, 1, 32'h0));
    vecs.push_back(mk(1, SZ_BYTE, 0, 10'h013, 32'hFFFF_FF7F, 0, 0, 32'h0));
    vecs.push_back(mk(0, SZ_WORD, 0, 10'h010, 32'h0,         1, 0, 32'h7FEF_3344));
    vecs.push_back(mk(0, SZ_BYTE, 1, 10'h013, 32'h0,         1, 0, 32'h0000_007F));
    vecs.push_back(mk(0, SZ_HALF, 0, 10'h012, 32'h0,         1, 0, 32'h0000_7FEF));
    vecs.push_back(mk(0, SZ_WORD, 0, 10'h004, 32'h0,         1, 0, 32'h0000_8000));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_misalign", bus.misalign, 0);
    check("rst_dout", bus.dout, 0);
`ifdef DM_PARAM_AUTOCLR_EN
    check("rst_busy", bus.busy, 1);
    check("rst_ready", bus.ready, 0);
    @(negedge clk) rst_n = 1'b1;
    count_busy("autoclr", -1);
`else
    check("rst_busy", bus.busy, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rel_ready", bus.ready, 1);
`endif

    for (int i = 0; i < vecs.size(); i++) access(vecs[i], $sformatf("v%0d", i));

    // Idle cycle: no response, dout held at zero
    @(posedge clk); #1;
    check("idle_rvalid", bus.rvalid, 0);
    check("idle_dout", bus.dout, 0);

    // Clear with a simultaneous (dropped) read, plus an ignored clr mid-clear
    access(mk(1, SZ_WORD, 0, 10'h3FC, 32'hFFFF_FFFF, 0, 0, 32'h0), "c_wr");
    access(mk(0, SZ_WORD, 0, 10'h3FC, 32'h0,         1, 0, 32'hFFFF_FFFF), "c_rd");
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = SZ_WORD; bus.addr = 10'h3FC; bus.clr = 1'b1;
    #1 check("clr_ready", bus.ready, 0);
    @(posedge clk);
    #1 bus.req = 1'b0; bus.clr = 1'b0;
    check("clr_busy", bus.busy, 1);
    count_busy("clear", 50);
    access(mk(0, SZ_WORD, 0, 10'h3FC, 32'h0, 1, 0, 32'h0), "c_after");
    access(mk(0, SZ_WORD, 0, 10'h010, 32'h0, 1, 0, 32'h0), "c_after2");

    // Reset while a misaligned read response is on the outputs
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = SZ_HALF; bus.addr = 10'h001;
    @(posedge clk);
    #1 bus.req = 1'b0;
    check("rr_rvalid_pre", bus.rvalid, 1);
    check("rr_mis_pre", bus.misalign, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rr_rvalid", bus.rvalid, 0);
    check("rr_mis", bus.misalign, 0);
    check("rr_dout", bus.dout, 0);
    @(negedge clk) rst_n = 1'b1;
`ifdef DM_PARAM_AUTOCLR_EN
    count_busy("rr_autoclr", -1);
`else
    #1 check("rr_ready", bus.ready, 1);
`endif

    // Reset at clear cycle 100
    access(mk(1, SZ_WORD, 0, 10'h3FC, 32'h1234_5678, 0, 0, 32'h0), "m_wr");
    @(negedge clk) bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
    repeat (100) @(posedge clk);
    #1 check("m_busy_pre", bus.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("m_rvalid", bus.rvalid, 0);
    check("m_mis", bus.misalign, 0);
    check("m_dout", bus.dout, 0);
`ifdef DM_PARAM_AUTOCLR_EN
    check("m_busy_rst", bus.busy, 1);
    check("m_ready_rst", bus.ready, 0);
    @(negedge clk) rst_n = 1'b1;
    count_busy("m_autoclr", -1);
    access(mk(0, SZ_WORD, 0, 10'h3FC, 32'h0, 1, 0, 32'h0), "m_rd");
`else
    check("m_busy_rst", bus.busy, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("m_ready_rel", bus.ready, 1);
    check("m_busy_rel", bus.busy, 0);
    access(mk(0, SZ_WORD, 0, 10'h3FC, 32'h0, 1, 0, 32'h1234_5678), "m_rd");
`endif

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
